pipeline_scheduler: RTL and testbench

PIPELINE_SCHEDULER -- requirements
Module: pipeline_scheduler

---
 rtl/pipeline_sched_pkg.sv | 17 +
 rtl/add_mul_stages.sv | 78 +++++++
 rtl/pipeline_scheduler.sv | 124 ++++++++++++
 tb/tb_pipeline_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_sched_pkg.sv
// Shared constants and the stage record for the (a+b)*c scheduler.
// The stage payload is sized from the package DATA_W, so override both together.
package pipeline_sched_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned RES_W     = 16;
    localparam int unsigned LATENCY   = 3;
    localparam int unsigned TAG_W     = 3;
    localparam int unsigned PAYLOAD_W = 3 * DATA_W;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W-1:0]     tag;
        logic [PAYLOAD_W-1:0] payload;
    } stage_t;

endpackage

// File: rtl/add_mul_stages.sv
// Three-stage (a+b)*c datapath carrying a valid/tag sideband; hold_i freezes every stage.
module add_mul_stages
    import pipeline_sched_pkg::TAG_W, pipeline_sched_pkg::PAYLOAD_W, pipeline_sched_pkg::stage_t;
#(
    parameter int unsigned DATA_W = pipeline_sched_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold_i,
    input  logic                  in_valid_i,
    input  logic [TAG_W-1:0]      in_tag_i,
    input  logic [DATA_W-1:0]     in_a_i,
    input  logic [DATA_W-1:0]     in_b_i,
    input  logic [DATA_W-1:0]     in_c_i,
    output logic                  out_valid_o,
    output logic [TAG_W-1:0]      out_tag_o,
    output logic [2*DATA_W:0]     out_product_o
);

    localparam int unsigned SUM_W  = DATA_W + 1;
    localparam int unsigned PROD_W = 2 * DATA_W + 1;

    stage_t s1_q, s1_d;
    stage_t s2_q, s2_d;
    stage_t s3_q, s3_d;

    logic [DATA_W-1:0] s1_a, s1_b, s1_c, s2_c;
    logic [SUM_W-1:0]  sum_c, s2_sum;
    logic [PROD_W-1:0] prod_c;
    logic              unused_payload_hi;

    assign s1_a   = s1_q.payload[DATA_W-1:0];
    assign s1_b   = s1_q.payload[2*DATA_W-1:DATA_W];
    assign s1_c   = s1_q.payload[3*DATA_W-1:2*DATA_W];
    assign s2_sum = s2_q.payload[SUM_W-1:0];
    assign s2_c   = s2_q.payload[SUM_W+DATA_W-1:SUM_W];

    // (2^D-1+2^D-1)*(2^D-1) < 2^(2D+1), so the product never wraps in PROD_W bits
    assign sum_c  = SUM_W'(s1_a) + SUM_W'(s1_b);
    assign prod_c = PROD_W'(s2_sum) * PROD_W'(s2_c);

    assign unused_payload_hi = ^{s2_q.payload[PAYLOAD_W-1:SUM_W+DATA_W],
                                 s3_q.payload[PAYLOAD_W-1:PROD_W]};

    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        if (!hold_i) begin
            s1_d.valid   = in_valid_i;
            s1_d.tag     = in_tag_i;
            s1_d.payload = PAYLOAD_W'({in_c_i, in_b_i, in_a_i});
            s2_d.valid   = s1_q.valid;
            s2_d.tag     = s1_q.tag;
            s2_d.payload = PAYLOAD_W'({s1_c, sum_c});
            s3_d.valid   = s2_q.valid;
            s3_d.tag     = s2_q.tag;
            s3_d.payload = PAYLOAD_W'(prod_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign out_valid_o   = s3_q.valid;
    assign out_tag_o     = s3_q.tag;
    assign out_product_o = s3_q.payload[PROD_W-1:0];

endmodule

// File: rtl/pipeline_scheduler.sv
// Round-robin arbiter feeding a shared (a+b)*c pipeline; results return tagged to their owner.
module pipeline_scheduler
    import pipeline_sched_pkg::TAG_W, pipeline_sched_pkg::LATENCY;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = pipeline_sched_pkg::DATA_W,
    parameter int unsigned RES_W   = pipeline_sched_pkg::RES_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pause,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*DATA_W-1:0] req_c,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [RES_W-1:0]          resp_result,
    output logic                      resp_overflow,
    output logic                      busy
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned PROD_W = 2 * DATA_W + 1;
    localparam int unsigned CNT_W  = $clog2(LATENCY + 1);

    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [IDX_W-1:0]  grant_idx_c, cand;
    logic              found_c, accept_c, retire_c;
    logic [CNT_W-1:0]  in_flight_q, in_flight_d;
    logic              busy_q;
    logic [DATA_W-1:0] sel_a, sel_b, sel_c;
    logic              s3_valid;
    logic [TAG_W-1:0]  s3_tag;
    logic [PROD_W-1:0] s3_product;

    // Rotating-priority search starting just after the last granted requester
    always_comb begin
        found_c     = 1'b0;
        grant_idx_c = last_grant_q;
        cand        = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((32'(last_grant_q) + off) % NUM_REQ);
            if (!found_c && req_valid[cand]) begin
                found_c     = 1'b1;
                grant_idx_c = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found_c && !pause && !reset) begin
            req_ready[grant_idx_c] = 1'b1;
        end
    end

    assign accept_c = |req_ready;
    assign retire_c = s3_valid && !pause;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_c == IDX_W'(i)) begin
                sel_a = req_a[i*DATA_W +: DATA_W];
                sel_b = req_b[i*DATA_W +: DATA_W];
                sel_c = req_c[i*DATA_W +: DATA_W];
            end
        end
    end

    add_mul_stages #(
        .DATA_W (DATA_W)
    ) u_stages (
        .clk           (clk),
        .rst           (reset),
        .hold_i        (pause),
        .in_valid_i    (accept_c),
        .in_tag_i      (TAG_W'(grant_idx_c)),
        .in_a_i        (sel_a),
        .in_b_i        (sel_b),
        .in_c_i        (sel_c),
        .out_valid_o   (s3_valid),
        .out_tag_o     (s3_tag),
        .out_product_o (s3_product)
    );

    always_comb begin
        last_grant_d = accept_c ? grant_idx_c : last_grant_q;
        in_flight_d  = in_flight_q;
        if (accept_c && !retire_c) begin
            in_flight_d = in_flight_q + CNT_W'(1);
        end else if (!accept_c && retire_c) begin
            in_flight_d = in_flight_q - CNT_W'(1);
        end
    end

    // last_grant resets to the top index so requester 0 wins the first search
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            in_flight_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            in_flight_q  <= in_flight_d;
            busy_q       <= (in_flight_d != '0);
        end
    end

    always_comb begin
        resp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = s3_valid && !pause && (s3_tag == TAG_W'(i));
        end
        resp_result   = s3_product[RES_W-1:0];
        resp_overflow = |s3_product[PROD_W-1:RES_W];
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_pipeline_scheduler.sv
// Randomized and directed bench for pipeline_scheduler against an in-flight list model.
module tb_pipeline_scheduler;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 8;
    localparam int RES_W   = 16;
    localparam int LAT     = 3;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      pause;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a, req_b, req_c;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [RES_W-1:0]          resp_result;
    logic                      resp_overflow;
    logic                      busy;

    always #5 clk = ~clk;

    pipeline_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .RES_W   (RES_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pause         (pause),
        .req_valid     (req_valid),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_c         (req_c),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_result   (resp_result),
        .resp_overflow (resp_overflow),
        .busy          (busy)
    );

    typedef struct {
        int tag;
        int a;
        int b;
        int c;
        int age;
    } op_t;

    op_t fly[$];
    int  lg = NUM_REQ - 1;
    bit  pend[NUM_REQ];
    int  pa[NUM_REQ];
    int  pb[NUM_REQ];
    int  pc[NUM_REQ];
    int  checks = 0;
    int  failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_pick();
        for (int off = 1; off <= NUM_REQ; off++) begin
            int i;
            i = (lg + off) % NUM_REQ;
            if (pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]               = pend[i];
            req_a[i*DATA_W +: DATA_W]  = DATA_W'(pa[i]);
            req_b[i*DATA_W +: DATA_W]  = DATA_W'(pb[i]);
            req_c[i*DATA_W +: DATA_W]  = DATA_W'(pc[i]);
        end
    endtask

    task automatic arm(input int i, input int a, input int b, input int c);
        pend[i] = 1'b1;
        pa[i] = a;
        pb[i] = b;
        pc[i] = c;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge
    task automatic cycle(input bit p);
        int g;
        int exp_rv;
        int prod;
        op_t o;
        pause = p;
        drive();
        @(negedge clk);
        g = model_pick();
        check_eq("req_ready", 32'(req_ready), (!p && !reset && g >= 0) ? (1 << g) : 0);
        exp_rv = 0;
        prod   = 0;
        foreach (fly[k]) begin
            if (fly[k].age == LAT) begin
                exp_rv = p ? 0 : (1 << fly[k].tag);
                prod   = (fly[k].a + fly[k].b) * fly[k].c;
            end
        end
        check_eq("resp_valid", 32'(resp_valid), exp_rv);
        if (exp_rv != 0) begin
            check_eq("resp_result", 32'(resp_result), prod % 65536);
            check_eq("resp_overflow", 32'(resp_overflow), (prod > 65535) ? 1 : 0);
        end
        if (reset) begin
            check_eq("rst_result", 32'(resp_result), 0);
            check_eq("rst_overflow", 32'(resp_overflow), 0);
        end
        check_eq("busy", 32'(busy), (fly.size() != 0) ? 1 : 0);
        check_eq("in_flight", 32'(dut.in_flight_q), fly.size());
        @(posedge clk);
        if (!reset && !p) begin
            foreach (fly[k]) fly[k].age++;
            while (fly.size() > 0 && fly[0].age > LAT) void'(fly.pop_front());
            if (g >= 0) begin
                o.tag = g; o.a = pa[g]; o.b = pb[g]; o.c = pc[g]; o.age = 1;
                fly.push_back(o);
                pend[g] = 1'b0;
                lg = g;
            end
        end
        #1;
    endtask

    // Reset raised between edges; outputs must clear before the next edge
    task automatic async_reset(input int hold_cycles);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_ready", 32'(req_ready), 0);
        check_eq("arst_resp_valid", 32'(resp_valid), 0);
        check_eq("arst_result", 32'(resp_result), 0);
        check_eq("arst_overflow", 32'(resp_overflow), 0);
        check_eq("arst_busy", 32'(busy), 0);
        fly.delete();
        lg = NUM_REQ - 1;
        repeat (hold_cycles) cycle(1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int exp_g[6];
        exp_g = '{0, 1, 2, 0, 1, 2};
        reset = 1'b1;
        pause = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b0; pa[i] = 0; pb[i] = 0; pc[i] = 0;
        end
        drive();
        repeat (2) cycle(1'b0);
        reset = 1'b0;

        // Single request: (5+3)*2 on requester 0
        arm(0, 5, 3, 2);
        cycle(1'b0);
        check_eq("single_busy_early", 32'(busy), 1);
        repeat (2) cycle(1'b0);
        check_eq("single_valid", 32'(resp_valid), 1);
        check_eq("single_result", 32'(resp_result), 16);
        repeat (3) cycle(1'b0);

        // Three continuous requesters rotate 0,1,2,0,1,2
        async_reset(1);
        for (int k = 0; k < 6; k++) begin
            arm(0, 10, 2, 4);
            arm(1, 3, 7, 3);
            arm(2, 8, 4, 5);
            drive();
            #1;
            check_eq("rr_grant", 32'(req_ready), 1 << exp_g[k]);
            cycle(1'b0);
        end
        repeat (4) cycle(1'b0);

        // Overflow case
        arm(1, 255, 255, 255);
        cycle(1'b0);
        repeat (2) cycle(1'b0);
        check_eq("ovf_valid", 32'(resp_valid), 2);
        check_eq("ovf_result", 32'(resp_result), 64514);
        check_eq("ovf_flag", 32'(resp_overflow), 1);
        repeat (2) cycle(1'b0);

        // Pause with three operations in flight
        arm(0, 1, 2, 3);
        arm(1, 4, 5, 6);
        arm(2, 7, 8, 9);
        repeat (3) cycle(1'b0);
        arm(0, 11, 12, 13);
        repeat (3) cycle(1'b1);
        repeat (6) cycle(1'b0);

        // Reset with two operations in flight
        arm(0, 20, 21, 2);
        arm(1, 30, 31, 3);
        repeat (2) cycle(1'b0);
        arm(2, 9, 9, 9);
        async_reset(2);
        repeat (6) cycle(1'b0);

        // Sparse requests: only 2, then only 0
        arm(2, 6, 6, 6);
        cycle(1'b0);
        arm(0, 40, 2, 7);
        cycle(1'b0);
        repeat (4) cycle(1'b0);

        // Randomized traffic with pauses and occasional resets
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    if ($urandom % 6 == 0) arm(i, 255, 255, $urandom_range(200, 255));
                    else arm(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
                end
            end
            if ($urandom % 120 == 0) async_reset(1);
            else cycle(($urandom % 5) == 0);
        end
        repeat (5) cycle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
